// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one 4-phase CDC handshake channel.
// Define CDC_HS_ARB_TIMEOUT_EN to abort stalled handshakes after TIMEOUT_CYCLES and flag err_timeout.
module cdc_handshake_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         sync_data,
    output logic                          sync_req,
    input  logic                          sync_ack,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int                 IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned        NREQ_U    = NUM_REQ;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ_HI  = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cdc_handshake_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_handshake_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            state;
    logic [IDX_W-1:0]      grant;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [NUM_REQ-1:0]    done_vec;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] c_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_data  = '0;
        cand       = 0;
        c_idx      = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NREQ_U) begin
                cand = cand - NREQ_U;
            end
            c_idx = IDX_W'(cand);
            if (!pick_valid && req_valid[c_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = c_idx;
                pick_data  = req_word[c_idx];
            end
        end
    end

    assign done_vec = NUM_REQ'(1) << grant;
    assign busy     = (state != IDLE);

`ifdef CDC_HS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] hs_count;
    logic             in_handshake;

    assign in_handshake = (state == REQ_HI) || (state == WAIT_LO);
    assign timeout_hit  = in_handshake && (hs_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_count    <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= timeout_hit;
            if (state == IDLE) begin
                hs_count <= '0;
            end else if (in_handshake && !timeout_hit) begin
                hs_count <= hs_count + CNT_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            sync_data <= '0;
            sync_req  <= 1'b0;
            req_done  <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_idx;
                        rr_ptr    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
                        sync_data <= pick_data;
                        sync_req  <= 1'b1;
                        state     <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    // Timeout wins over a coincident ack so the abort is always flagged.
                    if (timeout_hit) begin
                        sync_req <= 1'b0;
                        req_done <= done_vec;
                        state    <= DONE;
                    end else if (sync_ack) begin
                        sync_req <= 1'b0;
                        state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (timeout_hit || !sync_ack) begin
                        req_done <= done_vec;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    sync_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Scoreboard bench for cdc_handshake_arbiter; expected grants are queued as requests are raised.
// Compile with CDC_HS_ARB_TIMEOUT_EN defined to exercise the timeout abort path.
`timescale 1ns/1ps
module tb_cdc_handshake_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_done;
    logic [DW-1:0] sync_data;
    logic          sync_req;
    logic          sync_ack;
    logic          busy;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Receiving-side responder: raises ack hi_delay cycles after seeing sync_req, drops it lo_delay after it falls.
    bit   resp_en  = 1'b0;
    int   hi_delay = 0;
    int   lo_delay = 0;
    logic resp_ack = 1'b0;
    bit   saw_req  = 1'b0;
    int   rcnt     = 0;
    bit   ack_force = 1'b0;
    logic ack_val   = 1'b0;

    assign sync_ack = ack_force ? ack_val : resp_ack;

    cdc_handshake_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_done    (req_done),
        .sync_data   (sync_data),
        .sync_req    (sync_req),
        .sync_ack    (sync_ack),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !resp_en) begin
                resp_ack = 1'b0;
                saw_req  = 1'b0;
                rcnt     = 0;
            end else if (!saw_req) begin
                if (sync_req) begin
                    rcnt++;
                    if (rcnt > hi_delay) begin
                        resp_ack = 1'b1;
                        saw_req  = 1'b1;
                        rcnt     = 0;
                    end
                end
            end else if (!sync_req) begin
                rcnt++;
                if (rcnt > lo_delay) begin
                    resp_ack = 1'b0;
                    saw_req  = 1'b0;
                    rcnt     = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Runs until req_done is sampled or the cycle budget expires, collecting handshake observations.
    task automatic run_xfer(output bit got, output int idx, output logic [DW-1:0] data,
                            output int hi_cycles, output int cycles, output bit stable,
                            output bit onehot, output logic err);
        bit seen = 1'b0;
        got = 1'b0; idx = -1; data = '0; hi_cycles = 0; cycles = 0;
        stable = 1'b1; onehot = 1'b0; err = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            cycles++;
            if (sync_req) hi_cycles++;
            if (busy && sync_req && !seen) begin
                seen = 1'b1;
                data = sync_data;
            end else if (seen && busy && sync_data !== data) begin
                stable = 1'b0;
            end
            if (req_done !== '0) begin
                got    = 1'b1;
                err    = err_timeout;
                onehot = $onehot(req_done);
                for (int i = 0; i < NR; i++) if (req_done[i]) idx = i;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        step();
        checks++; if (sync_req !== 1'b0) begin errors++; $display("FAIL reset_sync_req: got %b expected 0", sync_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_done !== '0) begin errors++; $display("FAIL reset_req_done: got %b expected 0", req_done); end
        checks++; if (sync_data !== '0) begin errors++; $display("FAIL reset_sync_data: got %h expected 00", sync_data); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b expected 0", err_timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit got, stable, onehot; int idx, hi, cyc; logic [DW-1:0] d; logic err; exp_t e;
        do_reset();
        resp_en = 1'b1; hi_delay = 3; lo_delay = 3;
        req_data = '0;
        req_data[2*DW +: DW] = 8'hA5;
        req_valid = 4'b0100;
        exp_q.push_back('{idx: 2, data: 8'hA5});
        run_xfer(got, idx, d, hi, cyc, stable, onehot, err);
        e = exp_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL single_done_timeout: got no req_done expected one"); end
        checks++; if (idx != e.idx) begin errors++; $display("FAIL single_grant: got %0d expected %0d", idx, e.idx); end
        checks++; if (d !== e.data) begin errors++; $display("FAIL single_data: got %h expected %h", d, e.data); end
        checks++; if (hi != 4) begin errors++; $display("FAIL single_req_high: got %0d expected 4", hi); end
        checks++; if (!stable) begin errors++; $display("FAIL single_data_stable: got 0 expected 1"); end
        checks++; if (!onehot) begin errors++; $display("FAIL single_onehot: got %b expected one-hot", req_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
        req_valid = '0;
        step();
        checks++; if (req_done !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_back_idle: got done=%b busy=%b expected 0 0", req_done, busy);
        end
    endtask

    task automatic test_round_robin();
        bit got, stable, onehot; int idx, hi, cyc; logic [DW-1:0] d; logic err; exp_t e;
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        resp_en = 1'b1; hi_delay = 0; lo_delay = 0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
        req_valid = '1;
        for (int t = 0; t < 5; t++) exp_q.push_back('{idx: order[t], data: 8'(8'h10 + order[t])});
        for (int t = 0; t < 5; t++) begin
            run_xfer(got, idx, d, hi, cyc, stable, onehot, err);
            e = exp_q.pop_front();
            checks++; if (!got || idx != e.idx) begin errors++; $display("FAIL rr_grant_%0d: got %0d expected %0d", t, idx, e.idx); end
            checks++; if (d !== e.data) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", t, d, e.data); end
            checks++; if (!onehot || hi != 1) begin errors++; $display("FAIL rr_pulse_%0d: got onehot=%b req_high=%0d expected 1 1", t, onehot, hi); end
            if (t > 0) begin
                checks++; if (cyc != 4) begin errors++; $display("FAIL rr_txn_len_%0d: got %0d expected 4", t, cyc); end
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_early_ack();
        int hi = 0, wl = 0; bit got = 1'b0; int idx = -1; logic [DW-1:0] d = '0; exp_t e;
        do_reset();
        resp_en = 1'b0;
        ack_force = 1'b1; ack_val = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_idle_ack: got busy=%b expected 0", busy); end
        req_data = '0;
        req_data[1*DW +: DW] = 8'h3C;
        req_valid = 4'b0010;
        exp_q.push_back('{idx: 1, data: 8'h3C});
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            if (sync_req) begin hi++; d = sync_data; req_valid = '0; end
            if (req_done !== '0) begin
                got = 1'b1;
                for (int i = 0; i < NR; i++) if (req_done[i]) idx = i;
            end else if (busy && !sync_req && hi > 0) begin
                wl++;
                if (wl == 3) ack_val = 1'b0;
            end
        end
        e = exp_q.pop_front();
        checks++; if (hi != 1) begin errors++; $display("FAIL early_req_high: got %0d expected 1", hi); end
        checks++; if (wl != 3) begin errors++; $display("FAIL early_wait_lo: got %0d expected 3", wl); end
        checks++; if (!got || idx != e.idx || d !== e.data) begin
            errors++; $display("FAIL early_done: got idx=%0d data=%h expected %0d %h", idx, d, e.idx, e.data);
        end
        for (int c = 0; c < 4; c++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_no_regrant: got busy=%b expected 0", busy); end
        ack_force = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got, stable, onehot; int idx, hi, cyc; logic [DW-1:0] d; logic err; exp_t e;
        bit seen = 1'b0, in_wl = 1'b0, early_done = 1'b0;
        do_reset();
        resp_en = 1'b1; hi_delay = 1; lo_delay = 50;
        req_data = '0;
        req_data[3*DW +: DW] = 8'hC3;
        req_valid = 4'b1000;
        for (int c = 0; c < 20 && !in_wl; c++) begin
            step();
            if (req_done !== '0) early_done = 1'b1;
            if (sync_req) seen = 1'b1;
            else if (seen && busy) in_wl = 1'b1;
        end
        checks++; if (!in_wl || early_done) begin errors++; $display("FAIL rstmid_reach_wait_lo: got %b expected 1", in_wl); end
        rst_n = 1'b0;
        req_valid = '0;
        step();
        checks++; if (sync_req !== 1'b0) begin errors++; $display("FAIL rstmid_sync_req: got %b expected 0", sync_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (req_done !== '0) begin errors++; $display("FAIL rstmid_req_done: got %b expected 0", req_done); end
        checks++; if (sync_data !== '0) begin errors++; $display("FAIL rstmid_sync_data: got %h expected 00", sync_data); end
        step();
        rst_n = 1'b1; lo_delay = 2;
        req_data[0*DW +: DW] = 8'h01;
        req_data[1*DW +: DW] = 8'h02;
        req_valid = 4'b0011;
        exp_q.push_back('{idx: 0, data: 8'h01});
        exp_q.push_back('{idx: 1, data: 8'h02});
        for (int t = 0; t < 2; t++) begin
            run_xfer(got, idx, d, hi, cyc, stable, onehot, err);
            e = exp_q.pop_front();
            checks++; if (!got || idx != e.idx || d !== e.data) begin
                errors++; $display("FAIL rstmid_grant_%0d: got idx=%0d data=%h expected %0d %h", t, idx, d, e.idx, e.data);
            end
            if (got && idx >= 0) req_valid[idx] = 1'b0;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        resp_en = 1'b0;
        req_data = '0;
        req_data[1*DW +: DW] = 8'h5A;
        req_valid = 4'b0010;
`ifdef CDC_HS_ARB_TIMEOUT_EN
        begin
            bit got, stable, onehot; int idx, hi, cyc; logic [DW-1:0] d; logic err; exp_t e;
            exp_q.push_back('{idx: 1, data: 8'h5A});
            run_xfer(got, idx, d, hi, cyc, stable, onehot, err);
            e = exp_q.pop_front();
            checks++; if (!got || idx != e.idx) begin errors++; $display("FAIL timeout_done: got idx=%0d expected %0d", idx, e.idx); end
            checks++; if (hi != TO) begin errors++; $display("FAIL timeout_req_high: got %0d expected %0d", hi, TO); end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err_pulse: got %b expected 1", err); end
            req_valid = '0;
            step();
            checks++; if (err_timeout !== 1'b0 || req_done !== '0) begin
                errors++; $display("FAIL timeout_pulse_width: got err=%b done=%b expected 0 0", err_timeout, req_done);
            end
        end
`else
        begin
            int hi = 0; bit any_err = 1'b0, any_done = 1'b0;
            for (int c = 0; c < 3 * TO; c++) begin
                step();
                if (sync_req) hi++;
                if (err_timeout !== 1'b0) any_err = 1'b1;
                if (req_done !== '0) any_done = 1'b1;
            end
            checks++; if (sync_req !== 1'b1 || hi < 3 * TO - 2) begin
                errors++; $display("FAIL notimeout_req_held: got req=%b high=%0d expected 1 >=%0d", sync_req, hi, 3 * TO - 2);
            end
            checks++; if (any_err) begin errors++; $display("FAIL notimeout_err: got 1 expected 0"); end
            checks++; if (any_done) begin errors++; $display("FAIL notimeout_done: got pulse expected none"); end
        end
`endif
        do_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_ack();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
